msg_resp_write: RTL and testbench
=================================

Name: msg_resp_write

Overview:
- Downstream response stage of the message-read block.
- Captures each one-cycle OPB read strobe and its address, then waits for the slave's read acknowledge (or a timeout).
- Serializes a 10-byte response frame into the 8-bit TX FIFO, which the UART TX path drains toward the host.
- Frame layout mirrors the request format: header, ADDR[31:0] MSB first, DATA[31:0] MSB first, tail.

Parameters:
- HDR_BYTE, 8'h5B, response header byte.
- TAIL_OK, 8'hA4, tail byte when the slave acked.
- TAIL_TMO, 8'hAE, tail byte when the ack timed out.
- TMO_DATA, 32'hFFFF_FFFF, data field sent on timeout.
- ACK_TIMEOUT, 4, number of PULSE_2KHZ rising edges allowed in WAIT_ACK (must be >= 1).
- CNT_W, 8, width of the timeout counter (2^CNT_W > ACK_TIMEOUT).

Ports:
- OPB_CLK  in  1  single clock.
- OPB_RST_N  in  1  reset, synchronous, active-low.
- PULSE_2KHZ  in  1  timebase square wave; only its rising edge is used.
- OPB_RE  in  1  one-cycle read request from the message-read stage.
- OPB_ADDR  in  32  read address, valid when OPB_RE=1.
- OPB_DI  in  32  slave read data, valid when OPB_XFERACK=1.
- OPB_XFERACK  in  1  slave read acknowledge (one cycle).
- TX_FIFO_WR  out  1  TX FIFO write strobe.
- TX_FIFO_DATA  out  8  TX FIFO write byte.
- TX_FIFO_FULL  in  1  TX FIFO full flag.
- BUSY  out  1  high whenever state != IDLE.
- error_flag  out  1  one-cycle pulse on timeout or dropped request.

Behaviour:
- Clocking and reset: all state is registered on OPB_CLK.
  - OPB_RST_N=0 at a rising edge forces state=IDLE, byte index=0, timeout count=0, pulse-edge register=0, addr/data/tail regs=0, error_flag=0.
  - While in reset or IDLE: TX_FIFO_WR=0, TX_FIFO_DATA=8'h00, BUSY=0.
- States: IDLE, WAIT_ACK, SEND.
- IDLE, on OPB_RE=1:
  - Latch OPB_ADDR.
  - If OPB_XFERACK=1 in the same cycle: latch OPB_DI, tail=TAIL_OK, go to SEND.
  - Otherwise go to WAIT_ACK with count=0.
- WAIT_ACK:
  - OPB_XFERACK=1: latch OPB_DI, tail=TAIL_OK, go to SEND.
  - Else, on each PULSE_2KHZ rising edge (registered previous value is 0, current is 1), count+1.
  - When the incremented count reaches ACK_TIMEOUT: data=TMO_DATA, tail=TAIL_TMO, error_flag=1 for one cycle, go to SEND.
  - Ack and the final edge in the same cycle: ack wins, no error.
- SEND:
  - Byte index k in 0..9. TX_FIFO_DATA is a combinational mux of registered state: k=0 HDR_BYTE, k=1..4 ADDR[31:24]..[7:0], k=5..8 DATA[31:24]..[7:0], k=9 tail.
  - TX_FIFO_WR = (state==SEND) && !TX_FIFO_FULL.
  - k advances only on cycles where TX_FIFO_WR=1. No byte is ever written while full, and a stalled byte holds until FULL drops.
  - After k=9 is written: k=0, go to IDLE.
- Latency:
  - Ack in the request cycle: header written in cycle +1.
  - Ack in WAIT_ACK: header written the cycle after the ack.
  - FIFO never full: 10 consecutive write cycles.
- Ignored events:
  - OPB_XFERACK outside IDLE-with-OPB_RE and WAIT_ACK is ignored.
  - OPB_RE in WAIT_ACK or SEND is dropped: error_flag pulses, the in-progress frame is unaffected.
  - If a timeout and a dropped request occur in the same cycle, error_flag is a single pulse.
- The pulse-edge register updates in every state, so an edge seen in IDLE is never counted later.
- Reset mid-frame returns to IDLE immediately. Bytes already written stay in the FIFO; the host resynchronises on the header byte.

Decomposition:
- Shared package msg_pkg: HDR/TAIL byte constants (shared with the request parser), frame length 10, state encoding.
- No sub-module required. The pulse rising-edge detector may be a tiny shared module pulse_edge_det, reusable by the read stage.

Test Plan:
1. Ack with 1-cycle delay: OPB_RE with ADDR=32'h12345678, then OPB_XFERACK with DI=32'hAABBCCDD. Expect TX bytes 5B 12 34 56 78 AA BB CC DD A4 on 10 consecutive cycles, BUSY low afterwards, error_flag never high.
2. Same-cycle ack: OPB_RE and XFERACK together with DI=32'h11223344. Expect header in the next cycle, tail A4.
3. Timeout: OPB_RE with ADDR=32'hAABBCCDD, no ack. After the 4th PULSE_2KHZ rising edge, expect one error_flag pulse and frame 5B AA BB CC DD FF FF FF FF AE.
4. Backpressure: hold TX_FIFO_FULL=1 for 5 cycles while at byte k=3. Expect TX_FIFO_WR=0 throughout, byte 56 held on TX_FIFO_DATA, then the frame completes with no duplicate or missing byte.
5. Dropped request: second OPB_RE while in SEND. Expect a one-cycle error_flag pulse, the current frame unchanged, and no second frame.
6. Reset mid-frame: OPB_RST_N=0 at k=5. Expect TX_FIFO_WR=0 from the reset edge and BUSY=0. A new request then produces a complete correct frame.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared definitions for the message request/response path.
// Holds the frame framing bytes (also used by the request parser),
// the response frame length and the response FSM state encoding.
package msg_pkg;

  localparam logic [7:0] MSG_HDR_BYTE = 8'h5B;
  localparam logic [7:0] MSG_TAIL_OK  = 8'hA4;
  localparam logic [7:0] MSG_TAIL_TMO = 8'hAE;

  // header + 4 address bytes + 4 data bytes + tail
  localparam int FRAME_LEN = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_SEND     = 2'd2
  } state_t;

endpackage

// File: rtl/msg_resp_write_if.sv
// Bus bundle for msg_resp_write: OPB read request/acknowledge on the
// upstream side and the 8-bit TX FIFO write port on the downstream side.
//   slave  : view of the response stage (consumes OPB, writes the FIFO)
//   master : view of the environment (drives OPB and FIFO status)
interface msg_resp_write_if;

  logic        OPB_RE;
  logic [31:0] OPB_ADDR;
  logic [31:0] OPB_DI;
  logic        OPB_XFERACK;
  logic        TX_FIFO_WR;
  logic [7:0]  TX_FIFO_DATA;
  logic        TX_FIFO_FULL;

  modport slave (
    input  OPB_RE, OPB_ADDR, OPB_DI, OPB_XFERACK, TX_FIFO_FULL,
    output TX_FIFO_WR, TX_FIFO_DATA
  );

  modport master (
    output OPB_RE, OPB_ADDR, OPB_DI, OPB_XFERACK, TX_FIFO_FULL,
    input  TX_FIFO_WR, TX_FIFO_DATA
  );

endinterface

// File: rtl/pulse_edge_det.sv
// Rising-edge detector for a slow timebase square wave.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   din   : input level (already synchronous to clk)
//   rise  : high for the cycle where din=1 and the registered value was 0
module pulse_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/msg_resp_write.sv
// Response stage of the message-read block.
// Captures an OPB read request and its address, waits for the slave ack
// (or a timeout counted in PULSE_2KHZ rising edges), then writes a
// 10-byte frame into the TX FIFO:
//   HDR, ADDR[31:24..7:0], DATA[31:24..7:0], TAIL
// Ports:
//   OPB_CLK      : clock
//   OPB_RST_N    : synchronous active-low reset
//   PULSE_2KHZ   : timeout timebase, rising edges only
//   bus          : OPB request/ack inputs and TX FIFO write port
//   BUSY         : high whenever the FSM is not idle
//   error_flag   : one-cycle pulse on timeout or dropped request
module msg_resp_write
  import msg_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = MSG_HDR_BYTE,
  parameter logic [7:0]  TAIL_OK     = MSG_TAIL_OK,
  parameter logic [7:0]  TAIL_TMO    = MSG_TAIL_TMO,
  parameter logic [31:0] TMO_DATA    = 32'hFFFF_FFFF,
  parameter int          ACK_TIMEOUT = 4,
  parameter int          CNT_W       = 8
) (
  input  logic           OPB_CLK,
  input  logic           OPB_RST_N,
  input  logic           PULSE_2KHZ,
  msg_resp_write_if.slave bus,
  output logic           BUSY,
  output logic           error_flag
);

  localparam logic [3:0]       LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(ACK_TIMEOUT);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       tail_q, tail_d;
  logic             err_d;
  logic             pulse_rise;
  logic             wr_en;

  // Edge register runs in every state, so an edge seen while idle is
  // consumed there and never counted against a later request.
  pulse_edge_det u_pulse_edge (
    .clk   (OPB_CLK),
    .rst_n (OPB_RST_N),
    .din   (PULSE_2KHZ),
    .rise  (pulse_rise)
  );

  assign wr_en = (state_q == ST_SEND) && !bus.TX_FIFO_FULL;

  // State and datapath registers.
  // NOTE: the address/data/tail registers are small flops, not a memory,
  // so they are cleared with the FSM; nothing is left to power-up values.
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tail_q     <= '0;
      error_flag <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tail_q     <= tail_d;
      error_flag <= err_d;
    end
  end

  // Next-state and datapath update.
  // NOTE: every signal gets a hold/default value before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tail_d  = tail_q;
    err_d   = 1'b0;
    cnt_inc = cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.OPB_RE) begin
          addr_d = bus.OPB_ADDR;
          if (bus.OPB_XFERACK) begin
            data_d  = bus.OPB_DI;
            tail_d  = TAIL_OK;
            state_d = ST_SEND;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT_ACK;
          end
        end
      end

      ST_WAIT_ACK: begin
        // A request arriving now is dropped; the pending one continues.
        if (bus.OPB_RE) begin
          err_d = 1'b1;
        end
        // Ack takes priority over a simultaneous final timeout edge.
        if (bus.OPB_XFERACK) begin
          data_d  = bus.OPB_DI;
          tail_d  = TAIL_OK;
          cnt_d   = '0;
          state_d = ST_SEND;
        end else if (pulse_rise) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_CNT) begin
            data_d  = TMO_DATA;
            tail_d  = TAIL_TMO;
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        if (bus.OPB_RE) begin
          err_d = 1'b1;
        end
        if (wr_en) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs. Gated by reset so the FIFO sees no write while reset is held,
  // even before the first reset edge has cleared the state register.
  always_comb begin
    BUSY             = 1'b0;
    bus.TX_FIFO_WR   = 1'b0;
    bus.TX_FIFO_DATA = 8'h00;

    if (OPB_RST_N && state_q != ST_IDLE) begin
      BUSY = 1'b1;
    end

    if (OPB_RST_N && state_q == ST_SEND) begin
      bus.TX_FIFO_WR = wr_en;
      unique case (idx_q)
        4'd0:    bus.TX_FIFO_DATA = HDR_BYTE;
        4'd1:    bus.TX_FIFO_DATA = addr_q[31:24];
        4'd2:    bus.TX_FIFO_DATA = addr_q[23:16];
        4'd3:    bus.TX_FIFO_DATA = addr_q[15:8];
        4'd4:    bus.TX_FIFO_DATA = addr_q[7:0];
        4'd5:    bus.TX_FIFO_DATA = data_q[31:24];
        4'd6:    bus.TX_FIFO_DATA = data_q[23:16];
        4'd7:    bus.TX_FIFO_DATA = data_q[15:8];
        4'd8:    bus.TX_FIFO_DATA = data_q[7:0];
        4'd9:    bus.TX_FIFO_DATA = tail_q;
        default: bus.TX_FIFO_DATA = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_resp_write.sv
// Directed testbench for msg_resp_write. Inputs are driven 1 ns after the
// rising edge and outputs sampled 1 ns later, well away from the edge.
module tb_msg_resp_write;

  logic clk = 1'b0;
  logic rst_n;
  logic pulse;
  logic busy;
  logic err;

  msg_resp_write_if bus ();

  msg_resp_write dut (
    .OPB_CLK    (clk),
    .OPB_RST_N  (rst_n),
    .PULSE_2KHZ (pulse),
    .bus        (bus),
    .BUSY       (busy),
    .error_flag (err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] frame_t [10];

  int vectors     = 0;
  int miscompares = 0;

  // Per-capture log, filled by capture() and inspected by the tests.
  frame_t     got;
  int         n_got;
  int         n_cyc;
  int         err_cnt;
  logic       cyc_wr   [64];
  logic [7:0] cyc_data [64];
  logic       cyc_err  [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.OPB_RE       = 1'b0;
    bus.OPB_XFERACK  = 1'b0;
    bus.OPB_ADDR     = 32'h0;
    bus.OPB_DI       = 32'h0;
    bus.TX_FIFO_FULL = 1'b0;
  endtask

  // Runs cycles until `target` bytes are written or `budget` cycles pass.
  // FULL is held for capture cycles [full_start, full_start+full_len);
  // a junk request plus ack is injected on capture cycle drop_at.
  task automatic capture(input int target, input int budget,
                         input int full_start, input int full_len,
                         input int drop_at);
    n_got   = 0;
    n_cyc   = 0;
    err_cnt = 0;
    for (int i = 0; i < 10; i++) got[i] = 8'hxx;
    for (int c = 0; c < budget && c < 64; c++) begin
      bus.TX_FIFO_FULL = (c >= full_start) && (c < full_start + full_len);
      bus.OPB_RE       = (c == drop_at);
      bus.OPB_XFERACK  = (c == drop_at);
      bus.OPB_ADDR     = (c == drop_at) ? 32'h1111_1111 : 32'h0;
      bus.OPB_DI       = (c == drop_at) ? 32'h2222_2222 : 32'h0;
      #1;
      cyc_wr[c]   = bus.TX_FIFO_WR;
      cyc_data[c] = bus.TX_FIFO_DATA;
      cyc_err[c]  = err;
      if (err === 1'b1) err_cnt++;
      if (bus.TX_FIFO_WR === 1'b1 && n_got < 10) begin
        got[n_got] = bus.TX_FIFO_DATA;
        n_got++;
      end
      n_cyc++;
      tick();
      if (n_got == target) break;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pulse = 1'b0;
    idle_inputs();
    bus.OPB_RE      = 1'b1;
    bus.OPB_XFERACK = 1'b1;
    tick();
    tick();
    #1;
    vectors++;
    if (bus.TX_FIFO_WR !== 1'b0) begin
      miscompares++; $display("FAIL reset_wr: got %b expected 0", bus.TX_FIFO_WR);
    end
    vectors++;
    if (bus.TX_FIFO_DATA !== 8'h00) begin
      miscompares++; $display("FAIL reset_data: got %h expected 00", bus.TX_FIFO_DATA);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err: got %b expected 0", err);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
    // Ack without a request in IDLE must be ignored.
    bus.OPB_XFERACK = 1'b1;
    bus.OPB_DI      = 32'h5555_5555;
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (busy !== 1'b0 || bus.TX_FIFO_WR !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_stray_ack: got busy=%b wr=%b expected 0/0", busy, bus.TX_FIFO_WR);
    end
    tick();
  endtask

  task automatic test_ack_delay();
    frame_t exp;
    exp = '{8'h5B, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hA4};
    bus.OPB_RE   = 1'b1;
    bus.OPB_ADDR = 32'h1234_5678;
    tick();
    idle_inputs();
    bus.OPB_XFERACK = 1'b1;
    bus.OPB_DI      = 32'hAABB_CCDD;
    #1;
    vectors++;
    if (busy !== 1'b1 || bus.TX_FIFO_WR !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL ack1_wait: got busy=%b wr=%b err=%b expected 1/0/0", busy, bus.TX_FIFO_WR, err);
    end
    tick();
    capture(10, 20, -1, 0, -1);
    vectors++;
    if (cyc_wr[0] !== 1'b1 || n_cyc !== 10) begin
      miscompares++;
      $display("FAIL ack1_timing: got first_wr=%b cycles=%0d expected 1/10", cyc_wr[0], n_cyc);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL ack1_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
    #1;
    vectors++;
    if (busy !== 1'b0 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL ack1_end: got busy=%b errs=%0d expected 0/0", busy, err_cnt);
    end
  endtask

  task automatic test_same_cycle_ack();
    frame_t exp;
    exp = '{8'h5B, 8'h98, 8'h76, 8'h54, 8'h32, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA4};
    bus.OPB_RE      = 1'b1;
    bus.OPB_ADDR    = 32'h9876_5432;
    bus.OPB_XFERACK = 1'b1;
    bus.OPB_DI      = 32'h1122_3344;
    tick();
    capture(10, 20, -1, 0, -1);
    vectors++;
    if (cyc_wr[0] !== 1'b1 || cyc_data[0] !== 8'h5B || n_cyc !== 10) begin
      miscompares++;
      $display("FAIL same_timing: got wr=%b data=%h cycles=%0d expected 1/5b/10",
               cyc_wr[0], cyc_data[0], n_cyc);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL same_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++; $display("FAIL same_err: got %0d pulses expected 0", err_cnt);
    end
  endtask

  task automatic test_timeout();
    frame_t exp;
    exp = '{8'h5B, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hAE};
    pulse        = 1'b0;
    bus.OPB_RE   = 1'b1;
    bus.OPB_ADDR = 32'hAABB_CCDD;
    tick();
    idle_inputs();
    for (int p = 1; p <= 4; p++) begin
      pulse = 1'b1;
      #1;
      vectors++;
      if (err !== 1'b0 || bus.TX_FIFO_WR !== 1'b0) begin
        miscompares++;
        $display("FAIL tmo_edge%0d: got err=%b wr=%b expected 0/0", p, err, bus.TX_FIFO_WR);
      end
      tick();
      if (p < 4) begin
        pulse = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b1 || bus.TX_FIFO_WR !== 1'b0) begin
          miscompares++;
          $display("FAIL tmo_wait%0d: got busy=%b wr=%b expected 1/0", p, busy, bus.TX_FIFO_WR);
        end
        tick();
      end
    end
    pulse = 1'b0;
    capture(10, 20, -1, 0, -1);
    vectors++;
    if (err_cnt !== 1 || cyc_err[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_err: got pulses=%0d first=%b expected 1/1", err_cnt, cyc_err[0]);
    end
    vectors++;
    if (cyc_wr[0] !== 1'b1 || n_cyc !== 10) begin
      miscompares++;
      $display("FAIL tmo_timing: got first_wr=%b cycles=%0d expected 1/10", cyc_wr[0], n_cyc);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL tmo_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
  endtask

  // Edge seen in IDLE is not counted; ack on the 4th WAIT_ACK edge wins.
  task automatic test_ack_vs_timeout();
    frame_t exp;
    exp = '{8'h5B, 8'hCA, 8'hFE, 8'h00, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88, 8'hA4};
    pulse        = 1'b1;
    bus.OPB_RE   = 1'b1;
    bus.OPB_ADDR = 32'hCAFE_0001;
    tick();
    idle_inputs();
    tick();
    pulse = 1'b0;
    tick();
    for (int p = 1; p <= 3; p++) begin
      pulse = 1'b1;
      tick();
      pulse = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b1 || bus.TX_FIFO_WR !== 1'b0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL race_wait%0d: got busy=%b wr=%b err=%b expected 1/0/0",
                 p, busy, bus.TX_FIFO_WR, err);
      end
      tick();
    end
    pulse           = 1'b1;
    bus.OPB_XFERACK = 1'b1;
    bus.OPB_DI      = 32'h5566_7788;
    tick();
    pulse = 1'b0;
    capture(10, 20, -1, 0, -1);
    vectors++;
    if (err_cnt !== 0 || n_cyc !== 10) begin
      miscompares++;
      $display("FAIL race_err: got pulses=%0d cycles=%0d expected 0/10", err_cnt, n_cyc);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL race_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    frame_t exp;
    exp = '{8'h5B, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hA4};
    bus.OPB_RE      = 1'b1;
    bus.OPB_ADDR    = 32'h1234_5678;
    bus.OPB_XFERACK = 1'b1;
    bus.OPB_DI      = 32'h0A0B_0C0D;
    tick();
    capture(10, 30, 3, 5, -1);
    for (int c = 3; c < 8; c++) begin
      vectors++;
      if (cyc_wr[c] !== 1'b0 || cyc_data[c] !== 8'h56) begin
        miscompares++;
        $display("FAIL bp_stall%0d: got wr=%b data=%h expected 0/56", c, cyc_wr[c], cyc_data[c]);
      end
    end
    vectors++;
    if (n_cyc !== 15 || n_got !== 10) begin
      miscompares++;
      $display("FAIL bp_count: got cycles=%0d bytes=%0d expected 15/10", n_cyc, n_got);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL bp_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_dropped_request();
    frame_t exp;
    int     stray;
    exp = '{8'h5B, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA4};
    bus.OPB_RE      = 1'b1;
    bus.OPB_ADDR    = 32'hDEAD_BEEF;
    bus.OPB_XFERACK = 1'b1;
    bus.OPB_DI      = 32'h0102_0304;
    tick();
    capture(10, 30, -1, 0, 2);
    vectors++;
    if (err_cnt !== 1 || cyc_err[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_err: got pulses=%0d at3=%b expected 1/1", err_cnt, cyc_err[3]);
    end
    vectors++;
    if (n_cyc !== 10) begin
      miscompares++; $display("FAIL drop_cycles: got %0d expected 10", n_cyc);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL drop_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (busy !== 1'b0 || bus.TX_FIFO_WR !== 1'b0) stray++;
      tick();
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++; $display("FAIL drop_second_frame: got %0d busy cycles expected 0", stray);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_t exp;
    exp = '{8'h5B, 8'h13, 8'h57, 8'h9B, 8'hDF, 8'h24, 8'h68, 8'hAC, 8'hE0, 8'hA4};
    bus.OPB_RE      = 1'b1;
    bus.OPB_ADDR    = 32'h0F0E_0D0C;
    bus.OPB_XFERACK = 1'b1;
    bus.OPB_DI      = 32'h0B0A_0908;
    tick();
    capture(5, 10, -1, 0, -1);
    vectors++;
    if (n_got !== 5 || got[4] !== 8'h0C) begin
      miscompares++;
      $display("FAIL rstmid_pre: got bytes=%0d last=%h expected 5/0c", n_got, got[4]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.TX_FIFO_WR !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_assert: got wr=%b busy=%b expected 0/0", bus.TX_FIFO_WR, busy);
    end
    tick();
    #1;
    vectors++;
    if (bus.TX_FIFO_WR !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_held: got wr=%b busy=%b err=%b expected 0/0/0",
               bus.TX_FIFO_WR, busy, err);
    end
    rst_n = 1'b1;
    tick();
    #1;
    vectors++;
    if (busy !== 1'b0 || bus.TX_FIFO_WR !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_idle: got busy=%b wr=%b expected 0/0", busy, bus.TX_FIFO_WR);
    end
    bus.OPB_RE      = 1'b1;
    bus.OPB_ADDR    = 32'h1357_9BDF;
    bus.OPB_XFERACK = 1'b1;
    bus.OPB_DI      = 32'h2468_ACE0;
    tick();
    capture(10, 20, -1, 0, -1);
    vectors++;
    if (n_cyc !== 10 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL rstmid_frame: got cycles=%0d errs=%0d expected 10/0", n_cyc, err_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack_delay();
    test_same_cycle_ack();
    test_timeout();
    test_ack_vs_timeout();
    test_backpressure();
    test_dropped_request();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
